// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an async input and emits registered single-cycle rise/fall pulses.
// Latency: input change to rise/fall pulse is SYNC_STAGES+1 cycles.
// Backpressure: none; pulses are fire-and-forget.
module edge_sync
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    // Fewer than two stages is not a safe synchronizer, so clamp upward.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], sig_in};
        dly_d  = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~dly_q;
        fall_d = ~sync_q[STAGES-1] & dly_q;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow async square wave in sysclk cycles.
// Latency: results and valid appear one cycle after the internal rise pulse.
// Backpressure: none; valid is a one-cycle strobe the consumer must sample.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic rise;
    logic fall;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_latch_q, hi_latch_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_latch_d  = hi_latch_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;

        if (!enable) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            hi_latch_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d      = CNT_ONE;
                        hi_latch_d = '0;
                        state_d    = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // Rise takes priority over saturation so an exact 2^WIDTH-1 period still publishes.
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_latch_q;
                        valid_d     = 1'b1;
                        overflow_d  = 1'b0;
                        cnt_d       = CNT_ONE;
                        hi_latch_d  = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                        cnt_d      = '0;
                        hi_latch_d = '0;
                        state_d    = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) begin
                            hi_latch_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_latch_q  <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_latch_q  <= hi_latch_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench: a 16-bit meter for normal and divider waves, an 8-bit meter for saturation cases.
module tb_period_meter;

    logic        clk;
    logic        rst_n;
    logic        en_a, en_b;
    logic        sig_a, sig_b;
    logic [15:0] per_a, hi_a;
    logic [7:0]  per_b, hi_b;
    logic        vld_a, vld_b;
    logic        ovf_a, ovf_b;
    logic [1:0]  st_a, st_b;

    int n_checks = 0;
    int n_errs   = 0;
    int nv_a     = 0;
    int nv_b     = 0;
    int exp_per_a, exp_hi_a, exp_per_b, exp_hi_b;
    int base;
    logic prev_vld_a = 1'b0;
    logic prev_vld_b = 1'b0;
    logic [7:0] div;

    period_meter #(.WIDTH(16), .SYNC_STAGES(2)) u_dut_a (
        .sysclk    (clk),
        .reset     (rst_n),
        .enable    (en_a),
        .sig_in    (sig_a),
        .period    (per_a),
        .high_time (hi_a),
        .valid     (vld_a),
        .overflow  (ovf_a),
        .state     (st_a)
    );

    period_meter #(.WIDTH(8), .SYNC_STAGES(2)) u_dut_b (
        .sysclk    (clk),
        .reset     (rst_n),
        .enable    (en_b),
        .sig_in    (sig_b),
        .period    (per_b),
        .high_time (hi_b),
        .valid     (vld_b),
        .overflow  (ovf_b),
        .state     (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling clock edge; sel=0 drives meter A, sel=1 meter B.
    task automatic drive_wave(input bit sel, input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) sig_b = 1'b1; else sig_a = 1'b1;
            repeat (h) @(negedge clk);
            if (sel) sig_b = 1'b0; else sig_a = 1'b0;
            repeat (p - h) @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (vld_a) begin
            nv_a++;
            chk("a_period", per_a, exp_per_a);
            chk("a_high", hi_a, exp_hi_a);
            chk("a_ovf_at_valid", ovf_a, 0);
            chk("a_valid_pulse", prev_vld_a, 0);
        end
        if (vld_b) begin
            nv_b++;
            chk("b_period", per_b, exp_per_b);
            chk("b_high", hi_b, exp_hi_b);
            chk("b_ovf_at_valid", ovf_b, 0);
            chk("b_valid_pulse", prev_vld_b, 0);
        end
        prev_vld_a = vld_a;
        prev_vld_b = vld_b;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        exp_per_a = 0; exp_hi_a = 0; exp_per_b = 0; exp_hi_b = 0;
        div = 8'd0;
        repeat (3) @(negedge clk);

        chk("rst_a_period", per_a, 0);
        chk("rst_a_high", hi_a, 0);
        chk("rst_a_valid", vld_a, 0);
        chk("rst_a_ovf", ovf_a, 0);
        chk("rst_a_state", st_a, 0);
        chk("rst_b_period", per_b, 0);
        chk("rst_b_state", st_b, 0);

        rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("a_armed", st_a, 1);
        chk("b_armed", st_b, 1);

        // 8-bit meter: a 300-cycle period saturates the counter
        exp_per_b = 100; exp_hi_b = 40;
        base = nv_b;
        drive_wave(1, 300, 150, 1);
        chk("b_ovf_set", ovf_b, 1);
        chk("b_ovf_state_arm", st_b, 1);
        chk("b_ovf_no_valid", nv_b - base, 0);
        drive_wave(1, 100, 40, 1);
        chk("b_ovf_sticky", ovf_b, 1);
        drive_wave(1, 100, 40, 2);
        chk("b_ovf_cleared", ovf_b, 0);
        chk("b_valid_cnt_100", nv_b - base, 2);

        // Exactly 255 cycles between rises: rise beats saturation
        en_b = 1'b0;
        repeat (2) @(negedge clk);
        en_b = 1'b1;
        exp_per_b = 255; exp_hi_b = 100;
        base = nv_b;
        drive_wave(1, 255, 100, 3);
        chk("b_sat_valid_cnt", nv_b - base, 2);
        chk("b_sat_no_ovf", ovf_b, 0);
        chk("b_sat_state", st_b, 2);

        // 16-bit meter: basic 10/4 square wave
        exp_per_a = 10; exp_hi_a = 4;
        base = nv_a;
        drive_wave(0, 10, 4, 6);
        chk("a_basic_valid_cnt", nv_a - base, 5);

        // Divider loopback from an 8-bit counter MSB
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        en_a = 1'b1;
        exp_per_a = 256; exp_hi_a = 128;
        base = nv_a;
        div = 8'd0;
        for (int i = 0; i < 1024; i++) begin
            sig_a = div[7];
            @(negedge clk);
            div = div + 8'd1;
        end
        sig_a = 1'b0;
        chk("a_div_valid_cnt", nv_a - base, 3);

        // Enable drop mid-period
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        en_a = 1'b1;
        exp_per_a = 10; exp_hi_a = 4;
        base = nv_a;
        drive_wave(0, 10, 4, 3);
        sig_a = 1'b1;
        repeat (4) @(negedge clk);
        sig_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_pre_drop_valid_cnt", nv_a - base, 3);
        en_a = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_state_idle", st_a, 0);
        chk("drop_ovf", ovf_a, 0);
        chk("drop_valid", vld_a, 0);
        chk("drop_period_hold", per_a, 10);
        chk("drop_high_hold", hi_a, 4);
        @(negedge clk);
        en_a = 1'b1;
        base = nv_a;
        drive_wave(0, 10, 4, 1);
        chk("reen_one_rise", nv_a - base, 0);
        drive_wave(0, 10, 4, 3);
        chk("reen_valid_cnt", nv_a - base, 3);

        // Asynchronous reset between clock edges while measuring
        chk("pre_rst_state", st_a, 2);
        sig_a = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period", per_a, 0);
        chk("arst_high", hi_a, 0);
        chk("arst_valid", vld_a, 0);
        chk("arst_ovf", ovf_a, 0);
        chk("arst_state", st_a, 0);
        sig_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = nv_a;
        drive_wave(0, 10, 4, 1);
        chk("arst_one_rise", nv_a - base, 0);
        drive_wave(0, 10, 4, 1);
        chk("arst_two_rises", nv_a - base, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
